// File: rtl/rob_pkg.sv
// Types and constants shared by the fetch unit and the instruction queue so that
// the queue depth and the fetch-side credit width stay in lockstep.
package rob_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned IQ_DEPTH = 8;
  localparam int unsigned IQ_CNT_W = $clog2(IQ_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } fetch_state_e;

endpackage

// File: rtl/fetch_credit_counter.sv
// Occupancy counter for the instruction queue: +1 per visible write, -0..2 per cycle of reads,
// synchronous clear, saturating at zero on a read of an empty queue.
module fetch_credit_counter
  import rob_pkg::*;
#(
  parameter int unsigned CNT_W = IQ_CNT_W
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             up,
  input  logic             dn_odd,
  input  logic             dn_even,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next
);

  logic [CNT_W:0] avail;
  logic [CNT_W:0] dn;

  assign dn    = (CNT_W+1)'(dn_odd) + (CNT_W+1)'(dn_even);
  assign avail = {1'b0, count} + (CNT_W+1)'(up);

  always_comb begin
    count_next = '0;
    if (avail >= dn) begin
      count_next = CNT_W'(avail - dn);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

  // Reading more entries than are resident is a dispatch-side protocol error.
  no_underflow: assert property (@(posedge clk) disable iff (clear) avail >= dn);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-queue producer: streams a loaded program into the IQ one word per cycle,
// gated by occupancy credits, with flush redirect and end-of-program reporting.
module instr_fetch_unit
  import rob_pkg::*;
#(
  parameter int unsigned PROG_DEPTH = 16,
  parameter int unsigned PC_W       = $clog2(PROG_DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                prog_we,
  input  logic [PC_W-1:0]     prog_waddr,
  input  logic [INSTR_W-1:0]  prog_wdata,
  input  logic [PC_W:0]       prog_len,
  input  logic                start,
  input  logic                iq_rd_odd,
  input  logic                iq_rd_even,
  input  logic                flush,
  input  logic [PC_W-1:0]     flush_pc,
  output logic                write_instr,
  output logic [INSTR_W-1:0]  new_instr,
  output logic [PC_W-1:0]     fetch_pc,
  output logic [IQ_CNT_W-1:0] iq_count,
  output logic                busy,
  output logic                fetch_done
);

  localparam logic [IQ_CNT_W-1:0] IqFull = IQ_CNT_W'(IQ_DEPTH);

  logic [INSTR_W-1:0] mem [PROG_DEPTH];

  fetch_state_e        state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W:0]       len_q, len_d;
  logic                write_q, write_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [PC_W-1:0]     fpc_q, fpc_d;
  logic [IQ_CNT_W-1:0] count_next;
  logic                iq_free;
  logic                flush_hit;
  logic                do_issue;
  logic [PC_W-1:0]     issue_pc;
  logic [PC_W:0]       issue_len;

  assign flush_hit = flush && (state_q != IDLE);
  // Credit check includes the write currently on the port, so the queue can never exceed depth.
  assign iq_free   = (count_next < IqFull);

  fetch_credit_counter #(
    .CNT_W (IQ_CNT_W)
  ) u_credit (
    .clk        (clk),
    .clear      (reset || flush_hit),
    .up         (write_q),
    .dn_odd     (iq_rd_odd),
    .dn_even    (iq_rd_even),
    .count      (iq_count),
    .count_next (count_next)
  );

  always_ff @(posedge clk) begin
    if (prog_we && (state_q == IDLE)) begin
      mem[prog_waddr] <= prog_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    write_d   = 1'b0;
    instr_d   = instr_q;
    fpc_d     = fpc_q;
    do_issue  = 1'b0;
    issue_pc  = pc_q;
    issue_len = len_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          len_d = prog_len;
          if (prog_len == '0) begin
            state_d = DONE;
          end else begin
            state_d   = FETCH;
            pc_d      = '0;
            issue_pc  = '0;
            issue_len = prog_len;
            do_issue  = iq_free;
          end
        end
      end
      FETCH: do_issue = iq_free;
      // Wait for the final write to land as well as for the queue to empty.
      DRAIN: if ((iq_count == '0) && !write_q) state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (do_issue) begin
      write_d = 1'b1;
      instr_d = mem[issue_pc];
      fpc_d   = issue_pc;
      pc_d    = issue_pc + PC_W'(1);
      if ({1'b0, issue_pc} == issue_len - (PC_W+1)'(1)) begin
        state_d = DRAIN;
      end
    end

    if (flush_hit) begin
      write_d = 1'b0;
      instr_d = instr_q;
      fpc_d   = fpc_q;
      len_d   = len_q;
      pc_d    = flush_pc;
      state_d = ({1'b0, flush_pc} < len_q) ? FETCH : DRAIN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      write_q <= 1'b0;
      instr_q <= '0;
      fpc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      write_q <= write_d;
      instr_q <= instr_d;
      fpc_q   <= fpc_d;
    end
  end

  assign write_instr = write_q;
  assign new_instr   = instr_q;
  assign fetch_pc    = fpc_q;
  assign busy        = (state_q == FETCH) || (state_q == DRAIN);
  assign fetch_done  = (state_q == DONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a scoreboard queue of expected {pc, word} writes is
// filled as stimulus is issued and drained by a monitor whenever write_instr is seen.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_waddr;
  logic [31:0] prog_wdata;
  logic [4:0]  prog_len;
  logic        start;
  logic        iq_rd_odd;
  logic        iq_rd_even;
  logic        flush;
  logic [3:0]  flush_pc;
  logic        write_instr;
  logic [31:0] new_instr;
  logic [3:0]  fetch_pc;
  logic [3:0]  iq_count;
  logic        busy;
  logic        fetch_done;

  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];
  logic [31:0] prog_img [16];

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_waddr  (prog_waddr),
    .prog_wdata  (prog_wdata),
    .prog_len    (prog_len),
    .start       (start),
    .iq_rd_odd   (iq_rd_odd),
    .iq_rd_even  (iq_rd_even),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .write_instr (write_instr),
    .new_instr   (new_instr),
    .fetch_pc    (fetch_pc),
    .iq_count    (iq_count),
    .busy        (busy),
    .fetch_done  (fetch_done)
  );

  always #5 clk = ~clk;

  // Monitor: every visible write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && write_instr) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got pc=%0d data=%08h, required no write", fetch_pc,
                 new_instr);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        if ({fetch_pc, new_instr} !== e) begin
          n_err++;
          $display("FAIL sb_write: got pc=%0d data=%08h, required pc=%0d data=%08h",
                   fetch_pc, new_instr, e[35:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    prog_img[addr] = data;
    prog_we    = 1'b1;
    prog_waddr = addr[3:0];
    prog_wdata = data;
    step();
    prog_we    = 1'b0;
  endtask

  function automatic void push_exp(input int pc);
    exp_q.push_back({pc[3:0], prog_img[pc]});
  endfunction

  // Dispatch side reads one entry per cycle while any are resident, until DONE or budget.
  task automatic drain_until_done(input string nm);
    int n = 0;
    while (!fetch_done && n < 80) begin
      iq_rd_odd = (iq_count != 0);
      step();
      n++;
    end
    iq_rd_odd = 1'b0;
    check(nm, fetch_done, 1);
  endtask

  initial begin
    int nw;
    reset = 1'b1; prog_we = 0; prog_waddr = 0; prog_wdata = 0; prog_len = 0; start = 0;
    iq_rd_odd = 0; iq_rd_even = 0; flush = 0; flush_pc = 0;
    step(); step();
    reset = 1'b0;

    // T1: idle outputs, then empty program goes straight to DONE.
    for (int i = 0; i < 5; i++) begin
      step();
      check("t1_idle_outputs", {write_instr, new_instr, fetch_pc, iq_count, busy, fetch_done},
            0);
    end
    prog_len = 0; start = 1; step(); start = 0;
    check("t1_len0_done", {fetch_done, busy, write_instr}, 3'b100);

    // T2: four words, reads keep up, DRAIN then DONE.
    do_reset();
    load(0, 32'h11); load(1, 32'h22); load(2, 32'h33); load(3, 32'h44);
    for (int i = 0; i < 4; i++) push_exp(i);
    prog_len = 4; start = 1; step(); start = 0;
    check("t2_first_write", write_instr, 1);
    for (int i = 1; i < 4; i++) begin
      iq_rd_odd = (iq_count != 0);
      step();
      check("t2_consecutive", write_instr, 1);
    end
    iq_rd_odd = (iq_count != 0);
    step();
    check("t2_drain", {write_instr, busy, fetch_done}, 3'b010);
    drain_until_done("t2_done");
    check("t2_count_zero", iq_count, 0);

    // T3: backpressure with no reads fills exactly IQ_DEPTH entries.
    do_reset();
    for (int i = 0; i < 16; i++) load(i, 32'hA000_0000 + i * 32'h101);
    for (int i = 0; i < 8; i++) push_exp(i);
    prog_len = 12; start = 1; step(); start = 0;
    nw = int'(write_instr);
    for (int i = 0; i < 20; i++) begin
      step();
      nw += int'(write_instr);
    end
    check("t3_write_count", nw, 8);
    check("t3_full", {write_instr, iq_count}, {1'b0, 4'd8});
    push_exp(8);
    iq_rd_odd = 1; step(); iq_rd_odd = 0;
    check("t3_one_more", {write_instr, iq_count, fetch_pc}, {1'b1, 4'd7, 4'd8});
    step();
    check("t3_full_again", {write_instr, iq_count}, {1'b0, 4'd8});

    // T4: dual reads at full, then dual reads alongside a visible write.
    push_exp(9);
    iq_rd_odd = 1; iq_rd_even = 1; step();
    check("t4_dual_at_full", {write_instr, iq_count}, {1'b1, 4'd6});
    push_exp(10);
    step();
    iq_rd_odd = 0; iq_rd_even = 0;
    check("t4_dual_with_write", {write_instr, iq_count}, {1'b1, 4'd5});
    push_exp(11);
    step();
    check("t4_last_issue", {write_instr, iq_count, fetch_pc}, {1'b1, 4'd6, 4'd11});
    step();
    check("t4_drain", {write_instr, iq_count, busy}, {1'b0, 4'd7, 1'b1});
    drain_until_done("t4_done");

    // T5: flush at pc=5 back to pc=2.
    do_reset();
    for (int i = 0; i < 6; i++) push_exp(i);
    prog_len = 12; start = 1; step(); start = 0;
    for (int i = 0; i < 5; i++) step();
    check("t5_at_pc5", {write_instr, fetch_pc}, {1'b1, 4'd5});
    flush = 1; flush_pc = 2; step(); flush = 0;
    check("t5_flush_cycle", {write_instr, iq_count}, {1'b0, 4'd0});
    for (int i = 2; i < 12; i++) push_exp(i);
    step();
    check("t5_resume", {write_instr, fetch_pc, new_instr}, {1'b1, 4'd2, prog_img[2]});
    drain_until_done("t5_done");

    // T6: flush from DONE refetches; start and prog_we while busy are ignored.
    flush = 1; flush_pc = 9; prog_we = 1; prog_waddr = 10; prog_wdata = 32'hDEAD_BEEF;
    step();
    flush = 0; prog_we = 0;
    check("t6_flush_from_done", {busy, fetch_done, write_instr}, 3'b100);
    for (int i = 9; i < 12; i++) push_exp(i);
    prog_len = 4; start = 1; step(); start = 0;
    check("t6_start_ignored", {write_instr, fetch_pc}, {1'b1, 4'd9});
    drain_until_done("t6_done");
    check("t6_all_written", exp_q.size(), 0);
    flush = 1; flush_pc = 13; step(); flush = 0;
    check("t6_flush_past_len", {busy, write_instr, fetch_done}, 3'b100);
    step();
    check("t6_flush_past_len_done", fetch_done, 1);

    // T7: full-depth program, last pc compares against len-1 without wrapping.
    do_reset();
    for (int i = 0; i < 16; i++) push_exp(i);
    prog_len = 16; start = 1; step(); start = 0;
    drain_until_done("t7_done");
    for (int i = 0; i < 4; i++) step();
    check("t7_all_written", exp_q.size(), 0);
    check("t7_last_pc", fetch_pc, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
